// File: rtl/ast_arb_pkg.sv
// rtl/ast_arb_pkg.sv - shared state type and round-robin pick helper for ast_packet_arbiter
package ast_arb_pkg;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  localparam int unsigned MAX_SRC = 16;
  localparam int unsigned IDX_W   = 4;

  // Scan upward from ptr, wrapping at n; with no request the result is ptr and is ignored by callers.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int unsigned        n);
    logic [IDX_W-1:0] win;
    logic             found;
    int unsigned      idx;
    win   = ptr;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_SRC; off++) begin
      idx = (32'(ptr) + off) % n;
      if ((off < n) && !found && req[idx[IDX_W-1:0]]) begin
        win   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ast_rr_selector.sv
// rtl/ast_rr_selector.sv - combinational winner select; AST_ARB_FIXED_PRIO_EN selects fixed priority
module ast_rr_selector
  import ast_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int GNT_W = 2
) (
  input  logic [N_SRC-1:0] i_req,
`ifndef AST_ARB_FIXED_PRIO_EN
  input  logic [GNT_W-1:0] i_rr_ptr,
`endif
  output logic [GNT_W-1:0] o_winner
);

  logic [MAX_SRC-1:0] w_req_ext;
  logic [IDX_W-1:0]   w_ptr;

  always_comb begin
    w_req_ext = '0;
    w_req_ext[N_SRC-1:0] = i_req;
  end

`ifdef AST_ARB_FIXED_PRIO_EN
  // A scan anchored at zero is exactly lowest-index-wins.
  assign w_ptr = '0;
`else
  assign w_ptr = IDX_W'(i_rr_ptr);
`endif

  assign o_winner = GNT_W'(rr_pick(w_req_ext, w_ptr, N_SRC));

endmodule

// File: rtl/ast_packet_arbiter.sv
// rtl/ast_packet_arbiter.sv - packet-locked N:1 Avalon-ST arbiter; AST_ARB_FIXED_PRIO_EN selects fixed priority
module ast_packet_arbiter
  import ast_arb_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CHANNEL_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC*DATA_W-1:0]    snk_ast_data,
  input  logic [N_SRC-1:0]           snk_ast_startofpacket,
  input  logic [N_SRC-1:0]           snk_ast_endofpacket,
  input  logic [N_SRC-1:0]           snk_ast_valid,
  input  logic [N_SRC*EMPTY_W-1:0]   snk_ast_empty,
  output logic [N_SRC-1:0]           snk_ast_ready,
  output logic [DATA_W-1:0]          src_ast_data,
  output logic                       src_ast_startofpacket,
  output logic                       src_ast_endofpacket,
  output logic                       src_ast_valid,
  output logic [EMPTY_W-1:0]         src_ast_empty,
  output logic [CHANNEL_W-1:0]       src_ast_channel,
  input  logic                       src_ast_ready
);

  localparam int GNT_W = $clog2(N_SRC);

  if ((N_SRC < 2) || (N_SRC > 16)) begin : g_bad_nsrc
    $error("ast_packet_arbiter: N_SRC must be in 2..16");
  end
  if (CHANNEL_W < GNT_W) begin : g_bad_chan
    $error("ast_packet_arbiter: CHANNEL_W too narrow for N_SRC");
  end

  arb_state_t                      r_state;
  logic [GNT_W-1:0]                r_grant;
  logic [DATA_W-1:0]               r_data;
  logic                            r_sop;
  logic                            r_eop;
  logic                            r_valid;
  logic [EMPTY_W-1:0]              r_empty;
  logic [CHANNEL_W-1:0]            r_channel;

  logic [N_SRC-1:0][DATA_W-1:0]    w_data_arr;
  logic [N_SRC-1:0][EMPTY_W-1:0]   w_empty_arr;
  logic [GNT_W-1:0]                w_winner;
  logic                            w_out_free;
  logic                            w_accept;
  logic                            w_g_eop;

  assign w_data_arr  = snk_ast_data;
  assign w_empty_arr = snk_ast_empty;
  assign w_g_eop     = snk_ast_endofpacket[r_grant];
  assign w_out_free  = !r_valid || src_ast_ready;
  assign w_accept    = (r_state == BUSY) && snk_ast_valid[r_grant] && w_out_free;

`ifdef AST_ARB_FIXED_PRIO_EN
  ast_rr_selector #(.N_SRC(N_SRC), .GNT_W(GNT_W)) u_sel (
    .i_req    (snk_ast_valid),
    .o_winner (w_winner)
  );
`else
  logic [GNT_W-1:0] r_rr_ptr;
  logic [GNT_W-1:0] w_next_ptr;

  assign w_next_ptr = (r_grant == GNT_W'(N_SRC - 1)) ? '0 : r_grant + 1'b1;

  ast_rr_selector #(.N_SRC(N_SRC), .GNT_W(GNT_W)) u_sel (
    .i_req    (snk_ast_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_winner (w_winner)
  );
`endif

  // Only the locked source may see ready, and only while the output stage can take a beat.
  always_comb begin
    snk_ast_ready = '0;
    if (r_state == BUSY) snk_ast_ready[r_grant] = w_out_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_grant   <= '0;
`ifndef AST_ARB_FIXED_PRIO_EN
      r_rr_ptr  <= '0;
`endif
      r_data    <= '0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_valid   <= 1'b0;
      r_empty   <= '0;
      r_channel <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|snk_ast_valid) begin
            r_grant <= w_winner;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_accept && w_g_eop) begin
            r_state  <= IDLE;
`ifndef AST_ARB_FIXED_PRIO_EN
            r_rr_ptr <= w_next_ptr;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_accept) begin
        r_data    <= w_data_arr[r_grant];
        r_sop     <= snk_ast_startofpacket[r_grant];
        r_eop     <= w_g_eop;
        r_empty   <= w_empty_arr[r_grant];
        r_channel <= CHANNEL_W'(r_grant);
        r_valid   <= 1'b1;
      end else if (src_ast_ready) begin
        r_valid   <= 1'b0;
      end
    end
  end

  assign src_ast_data          = r_data;
  assign src_ast_startofpacket = r_sop;
  assign src_ast_endofpacket   = r_eop;
  assign src_ast_valid         = r_valid;
  assign src_ast_empty         = r_empty;
  assign src_ast_channel       = r_channel;

endmodule
